// File: rtl/coreriscv_axi4_grant_demux_2.sv
// Grant demultiplexer: a 2-entry beat queue that steers each TileLink Grant to one of two
// client ports, pins the route for a whole data burst, and latches protocol errors.
module coreriscv_axi4_grant_demux_2 #(
   parameter int ROUTE_BIT = 0,
   parameter int BEATS     = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic        io_in_ready,
   input  logic        io_in_valid,
   input  logic [2:0]  io_in_bits_addr_beat,
   input  logic [1:0]  io_in_bits_client_xact_id,
   input  logic        io_in_bits_manager_xact_id,
   input  logic        io_in_bits_is_builtin_type,
   input  logic [3:0]  io_in_bits_g_type,
   input  logic [63:0] io_in_bits_data,
   input  logic        io_out_0_ready,
   output logic        io_out_0_valid,
   output logic [2:0]  io_out_0_bits_addr_beat,
   output logic [1:0]  io_out_0_bits_client_xact_id,
   output logic        io_out_0_bits_manager_xact_id,
   output logic        io_out_0_bits_is_builtin_type,
   output logic [3:0]  io_out_0_bits_g_type,
   output logic [63:0] io_out_0_bits_data,
   input  logic        io_out_1_ready,
   output logic        io_out_1_valid,
   output logic [2:0]  io_out_1_bits_addr_beat,
   output logic [1:0]  io_out_1_bits_client_xact_id,
   output logic        io_out_1_bits_manager_xact_id,
   output logic        io_out_1_bits_is_builtin_type,
   output logic [3:0]  io_out_1_bits_g_type,
   output logic [63:0] io_out_1_bits_data,
   output logic        io_busy,
   output logic        io_err
);
   localparam int W = 75;

   logic [W-1:0] mem_q [2];
   logic         rd_ptr_q, wr_ptr_q;
   logic [1:0]   count_q, count_d;
   logic [2:0]   beat_cnt_q, beat_cnt_d;
   logic         lock_route_q, lock_route_d;
   logic         err_q, err_d;

   logic [W-1:0] in_word, head;
   logic [2:0]   head_addr_beat;
   logic [1:0]   head_cxid;
   logic         head_mxid, head_builtin;
   logic [3:0]   head_g_type;
   logic [63:0]  head_data;
   logic         empty, full, enq, deq, is_data, busy, sel, sel_ready;
   logic [1:0]   out_valid;

   assign in_word = {io_in_bits_addr_beat, io_in_bits_client_xact_id, io_in_bits_manager_xact_id,
                     io_in_bits_is_builtin_type, io_in_bits_g_type, io_in_bits_data};
   assign head = mem_q[rd_ptr_q];
   assign {head_addr_beat, head_cxid, head_mxid, head_builtin, head_g_type, head_data} = head;

   assign empty       = (count_q == 2'd0);
   assign full        = (count_q == 2'd2);
   assign io_in_ready = !full;
   assign enq         = io_in_valid && !full;

   assign is_data   = head_builtin ? (head_g_type == 4'h5) : (head_g_type == 4'h0);
   assign busy      = (beat_cnt_q != 3'd0);
   // Once a burst has started, the latched route wins over whatever id the beat carries.
   assign sel       = busy ? lock_route_q : head_cxid[ROUTE_BIT];
   assign sel_ready = sel ? io_out_1_ready : io_out_0_ready;
   assign deq       = !empty && sel_ready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         assign out_valid[gi] = !empty && (sel == 1'(gi));
      end
   endgenerate

   assign io_out_0_valid = out_valid[0];
   assign io_out_1_valid = out_valid[1];
   assign {io_out_0_bits_addr_beat, io_out_0_bits_client_xact_id, io_out_0_bits_manager_xact_id,
           io_out_0_bits_is_builtin_type, io_out_0_bits_g_type, io_out_0_bits_data} = head;
   assign {io_out_1_bits_addr_beat, io_out_1_bits_client_xact_id, io_out_1_bits_manager_xact_id,
           io_out_1_bits_is_builtin_type, io_out_1_bits_g_type, io_out_1_bits_data} = head;
   assign io_busy = busy;
   assign io_err  = err_q;

   always_comb begin
      count_d      = count_q + {1'b0, enq} - {1'b0, deq};
      beat_cnt_d   = beat_cnt_q;
      lock_route_d = lock_route_q;
      err_d        = err_q;
      if (deq) begin
         if (is_data) begin
            beat_cnt_d = (beat_cnt_q == 3'(BEATS - 1)) ? 3'd0 : beat_cnt_q + 3'd1;
            if (!busy) lock_route_d = sel;
         end
         if ((is_data && head_addr_beat != beat_cnt_q) ||
             (!is_data && busy) ||
             (busy && head_cxid[ROUTE_BIT] != lock_route_q))
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem_q[wr_ptr_q] <= in_word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         beat_cnt_q   <= 3'd0;
         lock_route_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (enq) wr_ptr_q <= ~wr_ptr_q;
         if (deq) rd_ptr_q <= ~rd_ptr_q;
         count_q      <= count_d;
         beat_cnt_q   <= beat_cnt_d;
         lock_route_q <= lock_route_d;
         err_q        <= err_d;
      end
   end
endmodule

// File: tb/tb_coreriscv_axi4_grant_demux_2.sv
// Scoreboarded bench for the Grant demux: directed bursts, backpressure, errors, reset.
module tb_coreriscv_axi4_grant_demux_2;
   logic        clk = 1'b0;
   logic        reset;
   logic        io_in_ready, io_in_valid;
   logic [2:0]  io_in_bits_addr_beat;
   logic [1:0]  io_in_bits_client_xact_id;
   logic        io_in_bits_manager_xact_id, io_in_bits_is_builtin_type;
   logic [3:0]  io_in_bits_g_type;
   logic [63:0] io_in_bits_data;
   logic        io_out_0_ready, io_out_0_valid;
   logic [2:0]  io_out_0_bits_addr_beat;
   logic [1:0]  io_out_0_bits_client_xact_id;
   logic        io_out_0_bits_manager_xact_id, io_out_0_bits_is_builtin_type;
   logic [3:0]  io_out_0_bits_g_type;
   logic [63:0] io_out_0_bits_data;
   logic        io_out_1_ready, io_out_1_valid;
   logic [2:0]  io_out_1_bits_addr_beat;
   logic [1:0]  io_out_1_bits_client_xact_id;
   logic        io_out_1_bits_manager_xact_id, io_out_1_bits_is_builtin_type;
   logic [3:0]  io_out_1_bits_g_type;
   logic [63:0] io_out_1_bits_data;
   logic        io_busy, io_err;

   int compared = 0;
   int mismatched = 0;
   logic [74:0] q0 [$];
   logic [74:0] q1 [$];

   coreriscv_axi4_grant_demux_2 #(.ROUTE_BIT(0), .BEATS(8)) dut (
      .clk(clk), .reset(reset),
      .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
      .io_in_bits_addr_beat(io_in_bits_addr_beat),
      .io_in_bits_client_xact_id(io_in_bits_client_xact_id),
      .io_in_bits_manager_xact_id(io_in_bits_manager_xact_id),
      .io_in_bits_is_builtin_type(io_in_bits_is_builtin_type),
      .io_in_bits_g_type(io_in_bits_g_type), .io_in_bits_data(io_in_bits_data),
      .io_out_0_ready(io_out_0_ready), .io_out_0_valid(io_out_0_valid),
      .io_out_0_bits_addr_beat(io_out_0_bits_addr_beat),
      .io_out_0_bits_client_xact_id(io_out_0_bits_client_xact_id),
      .io_out_0_bits_manager_xact_id(io_out_0_bits_manager_xact_id),
      .io_out_0_bits_is_builtin_type(io_out_0_bits_is_builtin_type),
      .io_out_0_bits_g_type(io_out_0_bits_g_type), .io_out_0_bits_data(io_out_0_bits_data),
      .io_out_1_ready(io_out_1_ready), .io_out_1_valid(io_out_1_valid),
      .io_out_1_bits_addr_beat(io_out_1_bits_addr_beat),
      .io_out_1_bits_client_xact_id(io_out_1_bits_client_xact_id),
      .io_out_1_bits_manager_xact_id(io_out_1_bits_manager_xact_id),
      .io_out_1_bits_is_builtin_type(io_out_1_bits_is_builtin_type),
      .io_out_1_bits_g_type(io_out_1_bits_g_type), .io_out_1_bits_data(io_out_1_bits_data),
      .io_busy(io_busy), .io_err(io_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else
         $display("ok   %s: %0h", name, act);
   endtask

   // Monitor: every beat handed to a client is popped from that port's scoreboard.
   always @(negedge clk) begin
      logic [74:0] got, exp;
      if (!reset) begin
         if (io_out_0_valid && io_out_0_ready) begin
            got = {io_out_0_bits_addr_beat, io_out_0_bits_client_xact_id, io_out_0_bits_manager_xact_id,
                   io_out_0_bits_is_builtin_type, io_out_0_bits_g_type, io_out_0_bits_data};
            compared++;
            if (q0.size() == 0) begin
               mismatched++;
               $display("FAIL port0_unexpected: got %0h expected none", got);
            end else begin
               exp = q0.pop_front();
               if (got !== exp) begin
                  mismatched++;
                  $display("FAIL port0_beat: got %0h expected %0h", got, exp);
               end else $display("ok   port0_beat beat=%0d data=%0h", got[74:72], got[63:0]);
            end
         end
         if (io_out_1_valid && io_out_1_ready) begin
            got = {io_out_1_bits_addr_beat, io_out_1_bits_client_xact_id, io_out_1_bits_manager_xact_id,
                   io_out_1_bits_is_builtin_type, io_out_1_bits_g_type, io_out_1_bits_data};
            compared++;
            if (q1.size() == 0) begin
               mismatched++;
               $display("FAIL port1_unexpected: got %0h expected none", got);
            end else begin
               exp = q1.pop_front();
               if (got !== exp) begin
                  mismatched++;
                  $display("FAIL port1_beat: got %0h expected %0h", got, exp);
               end else $display("ok   port1_beat beat=%0d data=%0h", got[74:72], got[63:0]);
            end
         end
      end
   end

   task automatic drive(input logic [2:0] ab, input logic [1:0] id, input logic bi,
                        input logic [3:0] gt, input logic [63:0] d);
      io_in_valid = 1'b1;
      io_in_bits_addr_beat = ab;
      io_in_bits_client_xact_id = id;
      io_in_bits_manager_xact_id = d[0];
      io_in_bits_is_builtin_type = bi;
      io_in_bits_g_type = gt;
      io_in_bits_data = d;
   endtask

   // Offer one beat, expecting it on port `port`; returns one cycle after it fires.
   task automatic send(input logic [2:0] ab, input logic [1:0] id, input logic bi,
                       input logic [3:0] gt, input logic [63:0] d, input int port);
      logic [74:0] w;
      bit done = 0;
      w = {ab, id, d[0], bi, gt, d};
      if (port == 0) q0.push_back(w); else q1.push_back(w);
      drive(ab, id, bi, gt, d);
      for (int i = 0; i < 100 && !done; i++) begin
         if (io_in_ready) done = 1;
         @(posedge clk); #1;
      end
      if (!done) begin
         compared++; mismatched++;
         $display("FAIL send_timeout: got in_ready=0 expected 1");
      end
      io_in_valid = 1'b0;
   endtask

   task automatic burst(input logic [1:0] id, input int first, input int last, input int port);
      for (int b = first; b <= last; b++)
         send(3'(b), id, 1'b1, 4'h5, 64'hD000_0000_0000_0000 | 64'(id * 16 + b), port);
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (q0.size() == 0 && q1.size() == 0 && !io_out_0_valid && !io_out_1_valid) done = 1;
         else begin @(posedge clk); #1; end
      end
      if (!done) begin
         compared++; mismatched++;
         $display("FAIL drain_timeout: got pending q0=%0d q1=%0d expected 0", q0.size(), q1.size());
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q0.delete(); q1.delete();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; io_in_valid = 1'b0;
      drive(3'd0, 2'd0, 1'b0, 4'h0, 64'd0); io_in_valid = 1'b0;
      io_out_0_ready = 1'b1; io_out_1_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;

      // 1: reset state and a single non-data Grant
      check("rst_in_ready", 64'(io_in_ready), 64'd1);
      check("rst_valid0", 64'(io_out_0_valid), 64'd0);
      check("rst_valid1", 64'(io_out_1_valid), 64'd0);
      check("rst_busy", 64'(io_busy), 64'd0);
      check("rst_err", 64'(io_err), 64'd0);
      io_out_0_ready = 1'b0;
      send(3'd0, 2'b00, 1'b1, 4'h0, 64'h1111, 0);
      check("t1_valid0_after_fire", 64'(io_out_0_valid), 64'd1);
      check("t1_valid1", 64'(io_out_1_valid), 64'd0);
      io_out_0_ready = 1'b1;
      drain();
      check("t1_busy", 64'(io_busy), 64'd0);
      check("t1_err", 64'(io_err), 64'd0);

      // 2: 8-beat data Grant to port 1
      burst(2'b01, 0, 3, 1);
      drain();
      check("t2_busy_mid", 64'(io_busy), 64'd1);
      burst(2'b01, 4, 7, 1);
      drain();
      check("t2_busy_end", 64'(io_busy), 64'd0);
      check("t2_err", 64'(io_err), 64'd0);

      // 3: backpressure on port 0
      io_out_0_ready = 1'b0;
      send(3'd0, 2'b00, 1'b1, 4'h0, 64'hA1, 0);
      send(3'd0, 2'b00, 1'b1, 4'h0, 64'hA2, 0);
      q0.push_back({3'd0, 2'b00, 1'b1, 1'b1, 4'h0, 64'hA3});
      drive(3'd0, 2'b00, 1'b1, 4'h0, 64'hA3);
      check("t3_full_in_ready", 64'(io_in_ready), 64'd0);
      @(posedge clk); #1;
      check("t3_still_full", 64'(io_in_ready), 64'd0);
      io_out_0_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_ready_after_deq", 64'(io_in_ready), 64'd1);
      @(posedge clk); #1;
      io_in_valid = 1'b0;
      drain();
      check("t3_err", 64'(io_err), 64'd0);

      // 4: route mismatch on beat 3 stays on the locked port and sets err
      burst(2'b00, 0, 2, 0);
      send(3'd3, 2'b01, 1'b1, 4'h5, 64'hB3, 0);
      burst(2'b00, 4, 7, 0);
      drain();
      check("t4_err", 64'(io_err), 64'd1);
      send(3'd0, 2'b01, 1'b1, 4'h0, 64'hB9, 1);
      drain();
      check("t4_err_sticky", 64'(io_err), 64'd1);
      do_reset();
      check("t4_err_cleared", 64'(io_err), 64'd0);

      // 5a: addr_beat sequence 0,1,3
      burst(2'b00, 0, 1, 0);
      drain();
      check("t5a_err_before", 64'(io_err), 64'd0);
      send(3'd3, 2'b00, 1'b1, 4'h5, 64'hC3, 0);
      drain();
      check("t5a_err_third", 64'(io_err), 64'd1);
      do_reset();
      // 5b: non-data Grant interleaved in a burst
      burst(2'b01, 0, 1, 1);
      drain();
      check("t5b_err_before", 64'(io_err), 64'd0);
      send(3'd0, 2'b00, 1'b0, 4'h3, 64'hC9, 1);
      drain();
      check("t5b_err_interleave", 64'(io_err), 64'd1);
      do_reset();

      // 6: reset mid-burst, then a fresh burst routes by its own id
      burst(2'b00, 0, 4, 0);
      check("t6_busy_before", 64'(io_busy), 64'd1);
      do_reset();
      check("t6_in_ready", 64'(io_in_ready), 64'd1);
      check("t6_valid0", 64'(io_out_0_valid), 64'd0);
      check("t6_busy", 64'(io_busy), 64'd0);
      check("t6_err", 64'(io_err), 64'd0);
      burst(2'b11, 0, 7, 1);
      drain();
      check("t6_fresh_busy", 64'(io_busy), 64'd0);
      check("t6_fresh_err", 64'(io_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
